// File: rtl/csr_mem_regs.sv
// Machine timer / software-interrupt register block (msip, mtime, mtimecmp)
// answering single-word CSR-port accesses with a one-cycle acknowledge.
module csr_mem_regs #(
    parameter int DATA_SIZE    = 32,
    parameter int CLOCK_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 csr_mem_rd_en,
    input  logic                 csr_mem_wr_en,
    input  logic [2:0]           csr_mem_addr,
    input  logic [DATA_SIZE-1:0] csr_mem_wr_data,
    output logic [DATA_SIZE-1:0] csr_mem_rd_data,
    output logic                 csr_mem_ack,
    output logic                 msip,
    output logic                 mtip
);

    localparam int PW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] SEL_MSIP  = 2'b00;
    localparam logic [1:0] SEL_MTIME = 2'b10;
    localparam logic [1:0] SEL_MTCMP = 2'b11;

    logic [1:0]           state_q, state_d;
    logic                 msip_q, msip_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 ack_q, ack_d;
    logic                 mtip_q, mtip_d;

    logic        req;
    logic        accept;
    logic        tick;
    logic        upper;
    logic [63:0] wdata64;
    logic [63:0] rsel;

    // At 32-bit width the upper address bit picks which half is replaced.
    function automatic logic [63:0] merge_word(input logic [63:0] old,
                                               input logic [63:0] wdata,
                                               input logic        hi);
        if (DATA_SIZE == 64) begin
            return wdata;
        end else if (hi) begin
            return {wdata[31:0], old[31:0]};
        end else begin
            return {old[63:32], wdata[31:0]};
        end
    endfunction

    function automatic logic [DATA_SIZE-1:0] read_word(input logic [63:0] val,
                                                       input logic        hi);
        if (DATA_SIZE == 64) begin
            return DATA_SIZE'(val);
        end else if (hi) begin
            return DATA_SIZE'(val[63:32]);
        end else begin
            return DATA_SIZE'(val[31:0]);
        end
    endfunction

    always_comb begin
        req        = csr_mem_rd_en | csr_mem_wr_en;
        accept     = (state_q == ST_IDLE) && req;
        upper      = csr_mem_addr[2];
        wdata64    = 64'(csr_mem_wr_data);

        state_d    = state_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        rd_data_d  = rd_data_q;
        ack_d      = 1'b0;

        tick       = (presc_q == PRESC_MAX);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtip_d     = (mtime_q >= mtimecmp_q);

        unique case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
            end
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: if (!req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rsel = '0;
        unique case (csr_mem_addr[1:0])
            SEL_MSIP:  rsel = {63'd0, msip_q};
            SEL_MTIME: rsel = mtime_q;
            SEL_MTCMP: rsel = mtimecmp_q;
            default:   rsel = '0;
        endcase

        // A simultaneous read+write is a write and returns zero; a register
        // write overrides the tick for that cycle.
        if (accept) begin
            rd_data_d = csr_mem_wr_en ? '0 : read_word(rsel, upper);
            if (csr_mem_wr_en) begin
                unique case (csr_mem_addr[1:0])
                    SEL_MSIP:  msip_d     = csr_mem_wr_data[0];
                    SEL_MTIME: mtime_d    = merge_word(mtime_q, wdata64, upper);
                    SEL_MTCMP: mtimecmp_d = merge_word(mtimecmp_q, wdata64, upper);
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            rd_data_q  <= '0;
            ack_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            rd_data_q  <= rd_data_d;
            ack_q      <= ack_d;
            mtip_q     <= mtip_d;
        end
    end

    assign csr_mem_rd_data = rd_data_q;
    assign csr_mem_ack     = ack_q;
    assign msip            = msip_q;
    assign mtip            = mtip_q;

endmodule

// File: doc/csr_mem_regs.md
# csr_mem_regs

Memory-mapped machine timer/software-interrupt register block (msip, mtime, mtimecmp) that acts as the responder on the memory controller's CSR port. It keeps a free-running 64-bit mtime counter with a prescaler and answers single-word reads and writes with a one-cycle acknowledge. It also drives the software-interrupt (msip) and timer-interrupt (mtip) lines to the CSR unit.

## Interface
- `DATA_SIZE`, 32: bus word width, 32 or 64; 32 splits 64-bit registers into halves.
- `CLOCK_CYCLES`, 1: clock cycles per mtime increment, ≥1.
- `clock  in  1`: system clock, rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `csr_mem_rd_en  in  1`: read request, held until acknowledged.
- `csr_mem_wr_en  in  1`: write request, held until acknowledged.
- `csr_mem_addr  in  3`: [1:0] register select (00 msip, 10 mtime, 11 mtimecmp, 01 reserved); [2] upper half (DATA_SIZE=32 only, ignored at 64).
- `csr_mem_wr_data  in  DATA_SIZE`: write data.
- `csr_mem_rd_data  out  DATA_SIZE`: registered read data, valid while `csr_mem_ack`=1.
- `csr_mem_ack  out  1`: one-cycle acknowledge; feeds the controller's CSR ack/busy input.
- `msip  out  1`: software interrupt pending (msip[0]).
- `mtip  out  1`: timer interrupt pending, registered (mtime >= mtimecmp).

## Operation
- Reset (reset=0 at a rising edge): msip=0, mtime=0, mtimecmp=all ones, prescaler=0, csr_mem_rd_data=0, csr_mem_ack=0, mtip=0, FSM→IDLE.
- FSM:
  - IDLE: on rd_en|wr_en → ACK; capture address/data; perform the access at this edge.
  - ACK: csr_mem_ack=1 for exactly this cycle; → HOLD.
  - HOLD: wait until rd_en=0 and wr_en=0, then → IDLE. No new request is accepted in ACK or HOLD.
- The controller holds a request until it sees the acknowledge. HOLD therefore guarantees exactly one access per request.
- rd_en and wr_en both high: treated as a write; csr_mem_rd_data=0.
- Writes:
  - msip: only wr_data[0] stored; other bits read as 0.
  - mtime/mtimecmp at DATA_SIZE=64: full replace.
  - mtime/mtimecmp at DATA_SIZE=32: addr[2]=0 replaces [31:0], addr[2]=1 replaces [63:32]; the other half holds its current value.
- Reads: zero-extended msip; selected register or half. Reserved address 01: reads 0, writes ignored, still acknowledged.
- Prescaler: counts 0..CLOCK_CYCLES-1. mtime += 1 (mod 2^64, wraps to 0) on the cycle the prescaler equals CLOCK_CYCLES-1. CLOCK_CYCLES=1 increments every cycle.
- Write to mtime in the same cycle as a tick: the write wins, with no increment that cycle; the prescaler keeps running.
- mtip: registered each cycle from the current mtime/mtimecmp, unsigned 64-bit compare.

## Timing
- Request sampled at edge N (FSM in IDLE). csr_mem_ack and csr_mem_rd_data are valid during cycle N+1; the write is visible to a read accepted at N+2 or later.
- Minimum request-to-request spacing: ack cycle, plus ≥1 cycle with both enables low, then a new request.
- csr_mem_rd_data holds its last value outside ack cycles; only the ack cycle is meaningful.
- msip updates the cycle after the write edge.
- mtip lags the mtime/mtimecmp change by one cycle.
- mtime read value is the value before the increment on the sampling edge.
- Reset mid-transaction (ACK/HOLD): immediate return to IDLE, ack=0; the pending request is lost and the master re-issues it.
- Wrap: 0xFFFF_FFFF_FFFF_FFFF → 0 on the next tick; mtip drops to 0 if mtimecmp > 0.

## Test plan
- Reset, then read mtimecmp halves (DATA_SIZE=32, addr 011/111) → 0xFFFFFFFF each, ack one cycle after request; mtip=0, msip=0.
- Write msip 0xFFFFFFFF → msip=1 next cycle, read back 0x00000001; write 0 → msip=0.
- CLOCK_CYCLES=4: read mtime low 40 cycles after reset → 10 (±1 per the sampling-edge rule); verify increments exactly every 4th cycle.
- Write mtimecmp = 20 (low 20, high 0) with CLOCK_CYCLES=1 → mtip rises the cycle after mtime reaches 20; rewrite mtimecmp=0xFFFFFFFF high → mtip falls next cycle.
- Write mtime low=0xFFFFFFFF and high=0xFFFFFFFF, then wait for ticks → mtime wraps to 0; a mtime write on a tick cycle stores the written value unincremented.
- Hold rd_en high for 5 cycles → exactly one ack pulse. Request on addr 01 → ack, data 0. Assert reset during HOLD → FSM in IDLE, ack=0, next request served normally.
